// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: state encodings, requester constants and round-robin search
package mux4_rr_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  localparam int N_REQ = 4;
  localparam logic [1:0] PTR_RST = 2'd3;
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] w;
    logic [1:0] idx;
    w = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) w = idx;
    end
    return w;
  endfunction
endpackage

// File: rtl/multiplexer4to1.sv
// multiplexer4to1: plain 4-to-1 bit multiplexer
module multiplexer4to1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);
  assign y = d[s];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing a 4:1 bit mux with a burst limit
// define MUX_ARB_LOCK_EN to add the lock input that suspends the burst limit
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       dout
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  state_t           state, state_d;
  logic [3:0]       gnt_d;
  logic [1:0]       sel_d, ptr, ptr_d, w;
  logic             valid_d, lock_on, take, mux_y;
  logic [CNT_W-1:0] cnt, cnt_d;
`ifdef MUX_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif
  assign w = rr_pick(req, ptr);
  // ptr tracks the owner, so the owner is always last in the search order
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    sel_d   = sel;
    valid_d = valid;
    cnt_d   = cnt;
    ptr_d   = ptr;
    take    = 1'b0;
    if (state == ST_IDLE) take = |req;
    else if (!req[sel]) begin
      take    = |req;
      state_d = ST_IDLE;
      gnt_d   = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end
    else if (lock_on) cnt_d = (cnt == LIMIT) ? LIMIT : cnt + ONE;
    else if (cnt < LIMIT) cnt_d = cnt + ONE;
    else if (|(req & ~gnt)) take = 1'b1;
    else cnt_d = ONE;
    if (take) begin
      state_d = ST_GRANT;
      gnt_d   = 4'b0001 << w;
      sel_d   = w;
      valid_d = 1'b1;
      cnt_d   = ONE;
      ptr_d   = w;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      sel   <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      ptr   <= PTR_RST;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      sel   <= sel_d;
      valid <= valid_d;
      cnt   <= cnt_d;
      ptr   <= ptr_d;
    end
  end
  multiplexer4to1 u_mux (.d(din), .s(sel), .y(mux_y));
  assign dout = mux_y & valid;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: random and directed checks of two arbiters against a behavioural model
module tb_mux4_rr_arbiter;
`ifdef MUX_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic       lock = 1'b0;
  logic [3:0] g0, g1;
  logic [1:0] s0, s1;
  logic       v0, v1, d0, d1;
  int n_cmp = 0;
  int n_bad = 0;
  int m_own[2];
  int m_run[2];
  int m_last[2];
  int m_sel[2];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_BURST(8), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
`ifdef MUX_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(g0), .sel(s0), .valid(v0), .dout(d0));

  mux4_rr_arbiter #(.MAX_BURST(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
`ifdef MUX_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(g1), .sel(s1), .valid(v1), .dout(d1));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic int limit(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  // model: owner index (-1 idle), length of the current run, last owner
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_own[i] = -1; m_run[i] = 0; m_last[i] = 3; m_sel[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nxt;
        bit go;
        nxt = search(req, m_last[i]);
        go = 1'b0;
        if (m_own[i] < 0) go = (req != 0);
        else if (!req[m_own[i]]) begin
          go = (req != 0);
          if (!go) begin m_own[i] = -1; m_run[i] = 0; end
        end
        else if (LOCK_EN && lock) m_run[i] = (m_run[i] + 1 > limit(i)) ? limit(i) : m_run[i] + 1;
        else if (m_run[i] < limit(i)) m_run[i]++;
        else if ((req & ~(4'b0001 << m_own[i])) != 0) go = 1'b1;
        else m_run[i] = 1;
        if (go) begin
          m_own[i] = nxt; m_run[i] = 1; m_last[i] = nxt; m_sel[i] = nxt;
        end
      end
    end
  end

  function automatic int egnt(input int i);
    return (m_own[i] < 0) ? 0 : (1 << m_own[i]);
  endfunction

  function automatic int edout(input int i);
    return (m_own[i] < 0) ? 0 : int'(din[m_own[i]]);
  endfunction

  always @(negedge clk) begin
    chk("u0.gnt", int'(g0), egnt(0));
    chk("u0.sel", int'(s0), m_sel[0]);
    chk("u0.valid", int'(v0), int'(m_own[0] >= 0));
    chk("u0.dout", int'(d0), edout(0));
    chk("u1.gnt", int'(g1), egnt(1));
    chk("u1.sel", int'(s1), m_sel[1]);
    chk("u1.valid", int'(v1), int'(m_own[1] >= 0));
    chk("u1.dout", int'(d1), edout(1));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req = '0; lock = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] exp_g [4];
    logic [3:0] exp_d;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_d = 4'b1010;
    do_reset;
    chk("reset gnt", int'(g0), 0);
    chk("reset sel", int'(s0), 0);
    chk("reset valid", int'(v0), 0);
    chk("reset dout", int'(d0), 0);
    req = 4'b0101; tick;
    chk("first gnt", int'(g0), 1);
    chk("first sel", int'(s0), 0);
    repeat (8) tick;
    chk("forced gnt", int'(g0), 4);
    chk("forced sel", int'(s0), 2);
    repeat (8) tick;
    chk("return gnt", int'(g0), 1);
    req = '0; din = 4'hF; tick;
    req = 4'b0010; tick;
    chk("own1 gnt", int'(g0), 2);
    req = 4'b1000; tick;
    chk("handoff gnt", int'(g0), 8);
    chk("handoff valid", int'(v0), 1);
    req = '0; tick;
    chk("idle gnt", int'(g0), 0);
    chk("idle valid", int'(v0), 0);
    chk("idle dout", int'(d0), 0);
    req = 4'b1000; tick;
    for (int k = 0; k < 20; k++) begin
      chk("single gnt", int'(g0), 8);
      tick;
    end
    do_reset;
    din = 4'b1010; req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rot1 gnt", int'(g1), int'(exp_g[k]));
      chk("rot1 dout", int'(d1), int'(exp_d[k]));
    end
    do_reset;
    req = 4'b0100; tick; tick;
    #2 rst_n = 1'b0;
    #1;
    chk("async gnt", int'(g0), 0);
    chk("async valid", int'(v0), 0);
    chk("async sel", int'(s0), 0);
    tick;
    rst_n = 1'b1; req = 4'b0010; tick;
    chk("post reset gnt", int'(g0), 2);
`ifdef MUX_ARB_LOCK_EN
    do_reset;
    req = 4'b0011; tick;
    chk("lock first gnt", int'(g0), 1);
    lock = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick;
      chk("lock hold gnt", int'(g0), 1);
    end
    lock = 1'b0; tick;
    chk("unlock gnt", int'(g0), 2);
`endif
    do_reset;
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      req = r;
      din = 4'($urandom);
      if ($urandom_range(7) == 0) lock = ~lock;
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
